// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-26 (x^26+x^6+x^2+x+1) sequence checker.
package prbs_pkg;

    localparam int PRBS_W = 26;
    localparam int TAP_A  = 19;
    localparam int TAP_B  = 23;
    localparam int TAP_C  = 24;
    localparam int TAP_D  = 25;

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } prbs_state_e;

    // Next sequence bit from a history register whose bit 0 is the most recent bit.
    function automatic logic prbs_predict(input logic [PRBS_W-1:0] r);
        return r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D];
    endfunction

endpackage

// File: rtl/prbs_win_mon.sv
// Error-density monitor: counts errors per WIN valid bits and strobes loss at LOSS_THR.
module prbs_win_mon
    import prbs_pkg::*;
#(
    parameter int LOSS_THR = 8,
    parameter int WIN      = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic vld,
    input  logic err,
    output logic loss
);

    localparam int WIN_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int ERR_W = $clog2(LOSS_THR + 1);

    logic [WIN_W-1:0] win_pos;
    logic [ERR_W-1:0] win_err;
    logic [ERR_W-1:0] err_base;
    logic [ERR_W-1:0] err_next;

    // Position 0 opens a new window, so an error landing there is its first count.
    always_comb begin
        err_base = (win_pos == '0) ? '0 : win_err;
        err_next = err_base + ERR_W'(err);
        loss     = active && vld && err && (err_next == ERR_W'(LOSS_THR));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || !active) begin
            win_pos <= '0;
            win_err <= '0;
        end else if (vld) begin
            win_pos <= win_pos + WIN_W'(1);
            win_err <= err_next;
        end
    end

endmodule

// File: rtl/prbs_checker.sv
// Self-synchronising PRBS-26 checker with lock detection and error counting.
// Optional `PRBS_CHK_BITCNT_EN adds a 32-bit count of valid bits checked while locked.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_CNT = 32,
    parameter int LOSS_THR = 8,
    parameter int WIN      = 256,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             din_vld,
    input  logic             din,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
`ifdef PRBS_CHK_BITCNT_EN
    ,
    output logic [31:0]      bit_cnt
`endif
);

    localparam int FILL_W  = $clog2(PRBS_W);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);

    prbs_state_e       state;
    logic [PRBS_W-1:0] r;
    logic [PRBS_W-1:0] r_in;
    logic [FILL_W-1:0] fill;
    logic [MATCH_W-1:0] match;
    logic              p;
    logic              mism;
    logic              in_lock;
    logic              lock_vld;
    logic              err;
    logic              loss;

    always_comb begin
        p        = prbs_predict(r);
        mism     = din ^ p;
        in_lock  = (state == LOCKED);
        lock_vld = din_vld && in_lock;
        err      = lock_vld && mism;
        r_in     = {r[PRBS_W-2:0], din};
    end

    prbs_win_mon #(
        .LOSS_THR (LOSS_THR),
        .WIN      (WIN)
    ) u_win_mon (
        .clk    (clk),
        .rst_n  (rst_n),
        .active (in_lock),
        .vld    (din_vld),
        .err    (err),
        .loss   (loss)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= HUNT;
            r         <= '0;
            fill      <= '0;
            match     <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
`ifdef PRBS_CHK_BITCNT_EN
            bit_cnt   <= '0;
`endif
        end else begin
            err_pulse <= err;

            // A clear that coincides with an error keeps that error.
            if (clr)
                err_cnt <= CNT_W'(err);
            else if (err && (err_cnt != '1))
                err_cnt <= err_cnt + CNT_W'(1);

`ifdef PRBS_CHK_BITCNT_EN
            if (clr)
                bit_cnt <= 32'(lock_vld);
            else if (lock_vld)
                bit_cnt <= bit_cnt + 32'd1;
`endif

            if (din_vld) begin
                case (state)
                    HUNT: begin
                        r <= r_in;
                        if (fill == FILL_W'(PRBS_W - 1)) begin
                            fill <= '0;
                            // An all-zero history is the LFSR lock-up state; keep hunting.
                            if (r_in != '0) begin
                                state <= VERIFY;
                                match <= '0;
                            end
                        end else begin
                            fill <= fill + FILL_W'(1);
                        end
                    end
                    VERIFY: begin
                        r <= r_in;
                        if (!mism) begin
                            if (match == MATCH_W'(LOCK_CNT - 1)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                match <= match + MATCH_W'(1);
                            end
                        end else begin
                            state <= HUNT;
                            fill  <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-running local generator: received bits are never fed back.
                        r <= {r[PRBS_W-2:0], p};
                        if (loss) begin
                            state  <= HUNT;
                            locked <= 1'b0;
                            fill   <= '0;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                        fill   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised self-checking bench for prbs_checker against a bit-level behavioural model.
module tb_prbs_checker;

    localparam int LOCK_CNT = 32;
    localparam int LOSS_THR = 8;
    localparam int WIN      = 256;
    localparam int CNT_W    = 4;
    localparam int ERR_MAX  = (1 << CNT_W) - 1;
    localparam int LOCK_LAT = 26 + LOCK_CNT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic             din_vld = 1'b0;
    logic             din = 1'b0;
    logic             locked;
    logic             err_pulse;
    logic [CNT_W-1:0] err_cnt;
`ifdef PRBS_CHK_BITCNT_EN
    logic [31:0]      bit_cnt;
`endif

    int checks = 0;
    int errors = 0;

    prbs_checker #(
        .LOCK_CNT (LOCK_CNT),
        .LOSS_THR (LOSS_THR),
        .WIN      (WIN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .din_vld   (din_vld),
        .din       (din),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
`ifdef PRBS_CHK_BITCNT_EN
        ,
        .bit_cnt   (bit_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Transmit sequence: s[n] = s[n-20] ^ s[n-24] ^ s[n-25] ^ s[n-26].
    bit tx[$];

    task automatic seed_tx();
        logic [25:0] s;
        s = 26'($urandom);
        if (s == '0) s = 26'd1;
        tx.delete();
        for (int i = 0; i < 26; i++) tx.push_back(s[i]);
    endtask

    task automatic tx_step(output bit b);
        b = tx[$-19] ^ tx[$-23] ^ tx[$-24] ^ tx[$-25];
        tx.push_back(b);
        void'(tx.pop_front());
    endtask

    // Behavioural model: mode 0 hunt, 1 verify, 2 locked.
    bit hq[$];
    int m_mode, m_fill, m_match, m_lk, m_werr, m_err_cnt, m_bit_cnt;
    bit exp_pulse;

    task automatic model_reset();
        hq.delete();
        for (int i = 0; i < 26; i++) hq.push_back(1'b0);
        m_mode = 0; m_fill = 0; m_match = 0; m_lk = 0; m_werr = 0;
        m_err_cnt = 0; m_bit_cnt = 0; exp_pulse = 1'b0;
    endtask

    task automatic model_cycle(input bit vld, input bit b, input bit c);
        bit p, e, was_lk, any;
        e = 1'b0;
        was_lk = (m_mode == 2);
        if (vld) begin
            p = hq[$-19] ^ hq[$-23] ^ hq[$-24] ^ hq[$-25];
            if (m_mode == 0) begin
                hq.push_back(b); void'(hq.pop_front());
                m_fill++;
                if (m_fill == 26) begin
                    m_fill = 0;
                    any = 1'b0;
                    foreach (hq[i]) any |= hq[i];
                    if (any) begin m_mode = 1; m_match = 0; end
                end
            end else if (m_mode == 1) begin
                hq.push_back(b); void'(hq.pop_front());
                if (b == p) begin
                    m_match++;
                    if (m_match == LOCK_CNT) begin m_mode = 2; m_lk = 0; m_werr = 0; end
                end else begin
                    m_mode = 0; m_fill = 0;
                end
            end else begin
                hq.push_back(p); void'(hq.pop_front());
                e = (b != p);
                if (m_lk % WIN == 0) m_werr = 0;
                if (e) m_werr++;
                m_lk++;
                if (m_werr == LOSS_THR) begin m_mode = 0; m_fill = 0; end
            end
        end
        if (c) begin
            m_err_cnt = int'(e);
            m_bit_cnt = int'(vld && was_lk);
        end else begin
            if (e && m_err_cnt < ERR_MAX) m_err_cnt++;
            if (vld && was_lk) m_bit_cnt++;
        end
        exp_pulse = e;
    endtask

    task automatic cycle(input bit vld, input bit b, input bit c);
        din_vld = vld;
        din     = vld ? b : 1'($urandom);
        clr     = c;
        @(posedge clk);
        #1;
        model_cycle(vld, b, c);
        din_vld = 1'b0;
        clr     = 1'b0;
    endtask

    task automatic send(input bit vld, input bit flip, input bit c);
        bit b;
        b = 1'b0;
        if (vld) begin
            tx_step(b);
            b ^= flip;
        end
        cycle(vld, b, c);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        din_vld = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
`ifdef PRBS_CHK_BITCNT_EN
        checks++; if (bit_cnt !== '0) begin errors++; $display("FAIL reset_bit_cnt: got %0d want 0", bit_cnt); end
`endif
        rst_n = 1'b1;
        model_reset();
        repeat (5) cycle(1'b0, 1'b0, 1'b0);
        checks++; if (locked !== 1'b0 || err_cnt !== '0) begin errors++; $display("FAIL idle_outputs: got locked=%b err_cnt=%0d want 0/0", locked, err_cnt); end
    endtask

    task automatic test_clean();
        int n, lock_at, pulses, pmis;
        seed_tx();
        n = 0; lock_at = -1;
        for (int i = 0; i < 200 && lock_at < 0; i++) begin
            send(1'b1, 1'b0, 1'b0);
            n++;
            checks++; if (locked !== (m_mode == 2)) begin errors++; $display("FAIL clean_locked_bit%0d: got %b want %b", n, locked, m_mode == 2); end
            if (locked === 1'b1) lock_at = n;
        end
        checks++; if (lock_at != LOCK_LAT) begin errors++; $display("FAIL clean_lock_point: got %0d want %0d", lock_at, LOCK_LAT); end
        pulses = 0; pmis = 0;
        for (int i = 0; i < 10000; i++) begin
            send(1'b1, 1'b0, 1'b0);
            if (err_pulse !== 1'b0) pulses++;
            if (err_pulse !== exp_pulse) pmis++;
        end
        checks++; if (pulses != 0 || pmis != 0) begin errors++; $display("FAIL clean_pulses: got %0d pulses %0d model diffs want 0/0", pulses, pmis); end
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL clean_err_cnt: got %0d want 0", err_cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL clean_still_locked: got %b want 1", locked); end
    endtask

    task automatic test_errors();
        for (int i = 0; i < 300 && (m_lk % WIN) != 0; i++) send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL err1_pulse: got %b want 1", err_pulse); end
        send(1'b1, 1'b0, 1'b0);
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL err1_pulse_width: got %b want 0", err_pulse); end
        checks++; if (err_cnt !== CNT_W'(1)) begin errors++; $display("FAIL err1_cnt: got %0d want 1", err_cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL err1_locked: got %b want 1", locked); end
        for (int k = 2; k <= LOSS_THR; k++) begin
            repeat (5) send(1'b1, 1'b0, 1'b0);
            send(1'b1, 1'b1, 1'b0);
            if (k == LOSS_THR - 1) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL err7_locked: got %b want 1", locked); end
            end
        end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL err8_loss: got %b want 0", locked); end
        checks++; if (err_cnt !== CNT_W'(LOSS_THR)) begin errors++; $display("FAIL err8_cnt: got %0d want %0d", err_cnt, LOSS_THR); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 200 && locked !== 1'b1; i++) send(1'b1, 1'b0, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_before_reset: got %b want 1", locked); end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (locked !== 1'b0 || err_cnt !== '0) begin errors++; $display("FAIL mid_reset: got locked=%b err_cnt=%0d want 0/0", locked, err_cnt); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_zeros_resync();
        int seen, n;
        apply_reset();
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            cycle(1'b1, 1'b0, 1'b0);
            if (locked !== 1'b0) seen++;
        end
        checks++; if (seen != 0 || m_mode != 0) begin errors++; $display("FAIL zeros_hunt: got %0d locked cycles, model mode %0d want 0/0", seen, m_mode); end
        apply_reset();
        seed_tx();
        for (int i = 0; i < 200 && !(m_mode == 1 && m_match == 20); i++) send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        checks++; if (locked !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("FAIL verify_bad_bit: got locked=%b pulse=%b want 0/0", locked, err_pulse); end
        n = 0;
        for (int i = 0; i < 200 && locked !== 1'b1; i++) begin
            send(1'b1, 1'b0, 1'b0);
            n++;
        end
        checks++; if (n != LOCK_LAT) begin errors++; $display("FAIL resync_point: got %0d want %0d", n, LOCK_LAT); end
        checks++; if (err_cnt !== '0) begin errors++; $display("FAIL verify_not_counted: got %0d want 0", err_cnt); end
    endtask

    task automatic test_window_wrap();
        for (int i = 0; i < 300 && (m_lk % WIN) != WIN - 7; i++) send(1'b1, 1'b0, 1'b0);
        repeat (7) send(1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_new_window: got %b want 1", locked); end
        repeat (6) send(1'b1, 1'b1, 1'b0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_seven: got %b want 1", locked); end
        send(1'b1, 1'b1, 1'b0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL wrap_eighth: got %b want 0", locked); end
        checks++; if (err_cnt !== CNT_W'(15)) begin errors++; $display("FAIL wrap_err_cnt: got %0d want 15", err_cnt); end
    endtask

    task automatic test_gaps();
        int vcount, lock_at, pos;
        bit vld, flip;
        apply_reset();
        seed_tx();
        vcount = 0; lock_at = -1;
        for (int i = 0; i < 2000 && lock_at < 0; i++) begin
            vld = 1'($urandom);
            send(vld, 1'b0, 1'b0);
            if (vld) vcount++;
            if (locked === 1'b1) lock_at = vcount;
        end
        checks++; if (lock_at != LOCK_LAT) begin errors++; $display("FAIL gaps_lock_point: got %0d want %0d", lock_at, LOCK_LAT); end
        for (int i = 0; i < 5000 && m_lk < 3 * WIN; i++) begin
            vld = 1'($urandom);
            pos = m_lk % WIN;
            flip = vld && (pos == 10 || pos == 40 || pos == 70 || pos == 100 || pos == 130 || pos == 160);
            send(vld, flip, 1'b0);
        end
        checks++; if (err_cnt !== CNT_W'(ERR_MAX)) begin errors++; $display("FAIL saturate: got %0d want %0d", err_cnt, ERR_MAX); end
        checks++; if (err_cnt !== CNT_W'(m_err_cnt)) begin errors++; $display("FAIL saturate_model: got %0d want %0d", err_cnt, m_err_cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL saturate_locked: got %b want 1", locked); end
        send(1'b0, 1'b0, 1'b1);
        checks++; if (err_cnt !== '0 || locked !== 1'b1) begin errors++; $display("FAIL clr_alone: got err_cnt=%0d locked=%b want 0/1", err_cnt, locked); end
        send(1'b1, 1'b1, 1'b1);
        checks++; if (err_cnt !== CNT_W'(1) || err_pulse !== 1'b1) begin errors++; $display("FAIL clr_with_error: got err_cnt=%0d pulse=%b want 1/1", err_cnt, err_pulse); end
    endtask

`ifdef PRBS_CHK_BITCNT_EN
    task automatic test_bit_cnt();
        int vcount;
        bit vld;
        send(1'b0, 1'b0, 1'b1);
        checks++; if (bit_cnt !== 32'd0) begin errors++; $display("FAIL bit_cnt_clr: got %0d want 0", bit_cnt); end
        vcount = 0;
        for (int i = 0; i < 5000 && vcount < 1000; i++) begin
            vld = 1'($urandom);
            send(vld, 1'b0, 1'b0);
            if (vld) vcount++;
        end
        checks++; if (bit_cnt !== 32'd1000) begin errors++; $display("FAIL bit_cnt_1000: got %0d want 1000", bit_cnt); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL bit_cnt_locked: got %b want 1", locked); end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_clean();
        test_errors();
        test_reset_mid();
        test_zeros_resync();
        test_window_wrap();
        test_gaps();
`ifdef PRBS_CHK_BITCNT_EN
        test_bit_cnt();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
